// File: rtl/vibration_motor.sv
// vibration_motor: plays a latched 8-slot PWM haptic pattern on trig edge (in: clk, rst_n-style active-low rst, trig, control, repeat_n; out: motor, busy, one-hot led)
module vibration_motor #(
  parameter int unsigned SLOT_DIV  = 2500000,
  parameter int unsigned PWM_DIV   = 2500,
  parameter int unsigned PWM_DUTY  = 1875,
  parameter int unsigned GAP_SLOTS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trig,
  input  logic [7:0] control,
  input  logic [1:0] repeat_n,
  output logic       motor,
  output logic       busy,
  output logic [7:0] led
);
  localparam int SW = SLOT_DIV > 1 ? $clog2(SLOT_DIV) : 1;
  localparam int PW = $clog2(PWM_DIV) + 1;
  localparam int GW = $clog2(GAP_SLOTS) + 1;
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
  state_t st, st_nx;
  logic [SW-1:0] slot, slot_nx;
  logic [PW-1:0] pwm, pwm_nx;
  logic [GW-1:0] gap, gap_nx;
  logic [2:0] idx, idx_nx;
  logic [1:0] rep, rep_nx;
  logic [7:0] pat, pat_nx;
  logic s1, s2, hist, trig_edge, tc;
  assign tc = 32'(slot) == SLOT_DIV - 1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      {s1, s2, hist} <= 3'b111;
      trig_edge <= 1'b0;
      st <= IDLE;
      slot <= '0;
      pwm <= '0;
      gap <= '0;
      idx <= '0;
      rep <= '0;
      pat <= '0;
      motor <= 1'b0;
      busy <= 1'b0;
      led <= '0;
    end else begin
      s1 <= trig;
      s2 <= s1;
      hist <= s2;
      trig_edge <= s2 & ~hist;
      st <= st_nx;
      slot <= slot_nx;
      pwm <= pwm_nx;
      gap <= gap_nx;
      idx <= idx_nx;
      rep <= rep_nx;
      pat <= pat_nx;
      motor <= st_nx == PLAY && pat_nx[idx_nx] && 32'(pwm_nx) < PWM_DUTY;
      busy <= st_nx != IDLE;
      led <= st_nx == PLAY ? 8'h80 >> (3'd7 - idx_nx) : 8'h00;
    end
  always_comb begin
    st_nx = st;
    slot_nx = slot;
    gap_nx = gap;
    idx_nx = idx;
    rep_nx = rep;
    pat_nx = pat;
    pwm_nx = 32'(pwm) == PWM_DIV - 1 ? '0 : pwm + 1'b1;
    if (st == IDLE) begin
      if (trig_edge && control != 8'h00) begin
        st_nx = PLAY;
        pat_nx = control;
        rep_nx = repeat_n;
        idx_nx = 3'd7;
        slot_nx = '0;
      end
    end else begin
      slot_nx = tc ? '0 : slot + 1'b1;
      if (tc && st == PLAY) begin
        if (idx != 3'd0) idx_nx = idx - 3'd1;
        else if (rep == 2'd0) st_nx = IDLE;
        else begin
          rep_nx = rep - 2'd1;
          gap_nx = '0;
          st_nx = GAP;
        end
      end
      if (tc && st == GAP) begin
        if (32'(gap) == GAP_SLOTS - 1) begin
          st_nx = PLAY;
          idx_nx = 3'd7;
        end else gap_nx = gap + 1'b1;
      end
    end
  end
endmodule
